// File: rtl/arbitro_rr_mux_pkg.sv
// Shared types and constants for the round-robin scheduler between the
// input FIFOs (0..3) and the output FIFOs (4..7) of the switching module.
package arbitro_pkg;

  typedef enum logic [1:0] {
    RESET,
    INIT,
    IDLE,
    ACTIVE
  } state_t;

  localparam int NUM_QUEUES = 4;
  localparam int DATA_WIDTH = 10;
  localparam int CNT_WIDTH  = 5;

  // The destination output FIFO sits in the two top bits of every word.
  localparam int DEST_MSB   = DATA_WIDTH - 1;
  localparam int DEST_LSB   = DATA_WIDTH - 2;
  localparam int DEST_WIDTH = DEST_MSB - DEST_LSB + 1;

endpackage

// File: rtl/arbitro_rr_mux_if.sv
// FIFO-side bundle of the scheduler: head words and flags coming in,
// one-hot pop/push strobes and the forwarded word going out.
interface arbitro_rr_mux_if
  import arbitro_pkg::*;
#(
  parameter int data_width = DATA_WIDTH
) ();

  logic [NUM_QUEUES-1:0] empty_in;
  logic [data_width-1:0] data_in0;
  logic [data_width-1:0] data_in1;
  logic [data_width-1:0] data_in2;
  logic [data_width-1:0] data_in3;
  logic [NUM_QUEUES-1:0] almost_full_out;
  logic [NUM_QUEUES-1:0] pop;
  logic [NUM_QUEUES-1:0] push;
  logic [data_width-1:0] data_out;

  modport master (
    input  empty_in,
    input  data_in0,
    input  data_in1,
    input  data_in2,
    input  data_in3,
    input  almost_full_out,
    output pop,
    output push,
    output data_out
  );

  modport slave (
    output empty_in,
    output data_in0,
    output data_in1,
    output data_in2,
    output data_in3,
    output almost_full_out,
    input  pop,
    input  push,
    input  data_out
  );

endinterface

// File: rtl/arbitro_rr_mux_rr_selector.sv
// Combinational round-robin picker: first eligible queue at or after rr,
// wrapping modulo the number of queues.
module rr_selector
  import arbitro_pkg::*;
(
  input  logic [NUM_QUEUES-1:0] eligible,
  input  logic [1:0]            rr,
  output logic                  grant_valid,
  output logic [1:0]            grant_idx
);

  logic [1:0] cand;

  // Scanning from the far end means the candidate closest to rr is kept last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr;
    cand        = rr;
    for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
      cand = rr + 2'(k);
      if (eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/arbitro_rr_mux.sv
// Round-robin scheduler moving one word per grant from FIFO0..3 to FIFO4..7,
// plus threshold configuration, IDLE flag and per-destination push counters.
module arbitro_rr_mux
  import arbitro_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int cnt_width  = CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [2:0]           alto_in,
  input  logic [2:0]           bajo_in,
  input  logic                 req,
  input  logic [1:0]           idx,
  output logic [2:0]           alto,
  output logic [2:0]           bajo,
  output logic                 idle,
  output logic                 valid_contador,
  output logic [cnt_width-1:0] contador_out,
  arbitro_rr_mux_if.master     fifo
);

  state_t                state;
  logic [1:0]            rr;
  logic [NUM_QUEUES-1:0] pop_q;
  logic [NUM_QUEUES-1:0] push_q;
  logic [data_width-1:0] data_q;
  logic [cnt_width-1:0]  count [NUM_QUEUES];

  logic [data_width-1:0] head [NUM_QUEUES];
  logic [DEST_WIDTH-1:0] dest [NUM_QUEUES];
  logic [NUM_QUEUES-1:0] eligible;
  logic                  grant_en;
  logic                  grant_valid;
  logic [1:0]            grant_idx;

  assign head[0] = fifo.data_in0;
  assign head[1] = fifo.data_in1;
  assign head[2] = fifo.data_in2;
  assign head[3] = fifo.data_in3;

  assign fifo.pop      = pop_q;
  assign fifo.push     = push_q;
  assign fifo.data_out = data_q;

  // A pending init freezes new grants so the FSM can leave once the bus drains.
  assign grant_en = (state == ACTIVE) && !init;

  // A queue popped this cycle still shows its old empty flag, so it sits out one round.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      dest[i]     = head[i][data_width-1 -: DEST_WIDTH];
      eligible[i] = grant_en && !fifo.empty_in[i] &&
                    !fifo.almost_full_out[dest[i]] && !pop_q[i];
    end
  end

  rr_selector u_rr_selector (
    .eligible    (eligible),
    .rr          (rr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Control FSM, registered strobes, thresholds, counters and readout port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= RESET;
      rr             <= '0;
      pop_q          <= '0;
      push_q         <= '0;
      data_q         <= '0;
      alto           <= '0;
      bajo           <= '0;
      idle           <= 1'b0;
      valid_contador <= 1'b0;
      contador_out   <= '0;
      for (int d = 0; d < NUM_QUEUES; d++) begin
        count[d] <= '0;
      end
    end else begin
      pop_q          <= '0;
      push_q         <= '0;
      valid_contador <= 1'b0;

      for (int d = 0; d < NUM_QUEUES; d++) begin
        if (push_q[d]) begin
          count[d] <= count[d] + cnt_width'(1);
        end
      end

      case (state)
        RESET: begin
          state <= INIT;
        end

        INIT: begin
          if (init) begin
            alto <= alto_in;
            bajo <= bajo_in;
          end else begin
            state <= IDLE;
            idle  <= 1'b1;
          end
        end

        IDLE: begin
          if (req) begin
            valid_contador <= 1'b1;
            contador_out   <= count[idx];
          end
          if (init) begin
            state <= INIT;
            idle  <= 1'b0;
          end else if (fifo.empty_in != '1) begin
            state <= ACTIVE;
            idle  <= 1'b0;
          end
        end

        ACTIVE: begin
          if (init) begin
            if (pop_q == '0) begin
              state <= INIT;
            end
          end else if (grant_valid) begin
            pop_q[grant_idx]        <= 1'b1;
            push_q[dest[grant_idx]] <= 1'b1;
            data_q                  <= head[grant_idx];
            rr                      <= grant_idx + 2'd1;
          end else if ((fifo.empty_in == '1) && (pop_q == '0)) begin
            state <= IDLE;
            idle  <= 1'b1;
          end
        end

        default: begin
          state <= RESET;
        end
      endcase
    end
  end

endmodule
